// File: rtl/rpn_sequencer.sv
// rtl/rpn_sequencer.sv - RPN token sequencer driving an operand stack
//
// Accepts a postfix token stream, issues push/add/mul/pop opcodes to the
// attached stack, tracks stack depth, detects malformed expressions and
// returns the final value (or an error code) on the result port.
//
// Optional feature macro: RPN_OVF_CHECK_EN
//   defined   - stk_overflow after add/mul aborts the expression with err=3
//   undefined - stk_overflow is ignored, wrapped results complete normally
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   tok_valid/ready   token handshake
//   tok_is_op         1 = operator, 0 = operand
//   tok_data          operand value, or operator code in [1:0]
//   tok_last          final token of the expression
//   stk_opcode        000 nop, 100 add, 101 mul, 110 push, 111 pop
//   stk_data          push data
//   stk_out           stack output data
//   stk_full          stack full
//   stk_overflow      stack arithmetic overflow
//   res_valid/ready   result handshake
//   res_data          final value (0 on error)
//   res_err           0 ok, 1 underflow, 2 full, 3 overflow, 4 bad depth, 5 bad op

module rpn_sequencer #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic             tok_is_op,
  input  logic [WIDTH-1:0] tok_data,
  input  logic             tok_last,
  output logic [2:0]       stk_opcode,
  output logic [WIDTH-1:0] stk_data,
  input  logic [WIDTH-1:0] stk_out,
  input  logic             stk_full,
  input  logic             stk_overflow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [2:0]       res_err
);

  localparam int             DW        = $clog2(DEPTH + 1);
  localparam logic [DW-1:0]  DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0]  ONE       = DW'(1);
  localparam logic [DW-1:0]  TWO       = DW'(2);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [2:0] E_OK    = 3'd0;
  localparam logic [2:0] E_UNDER = 3'd1;
  localparam logic [2:0] E_FULL  = 3'd2;
  localparam logic [2:0] E_OVF   = 3'd3;
  localparam logic [2:0] E_DEPTH = 3'd4;
  localparam logic [2:0] E_BADOP = 3'd5;

  typedef enum logic [3:0] {
    ACCEPT, EXEC, SETTLE, FPOP, FWAIT, DRAIN, CLEAN, CWAIT, RESULT
  } state_t;

  state_t        state;
  logic [DW-1:0] depth;
  logic [2:0]    err;
  logic          last_q;   // accepted token carried tok_last
  logic          arith_q;  // accepted token issued add/mul

  logic          tok_hs;
  logic [2:0]    settle_err;

  assign tok_hs = tok_valid & tok_ready;

  // Error as seen in SETTLE, including a late arithmetic overflow.
  always_comb begin
    settle_err = err;
`ifdef RPN_OVF_CHECK_EN
    if (err == E_OK && arith_q && stk_overflow) settle_err = E_OVF;
`endif
  end

`ifndef RPN_OVF_CHECK_EN
  logic unused_ovf;
  assign unused_ovf = stk_overflow & arith_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCEPT;
      depth      <= '0;
      err        <= E_OK;
      last_q     <= 1'b0;
      arith_q    <= 1'b0;
      tok_ready  <= 1'b0;
      stk_opcode <= OP_NOP;
      stk_data   <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_err    <= E_OK;
    end else begin
      case (state)
        ACCEPT: begin
          if (tok_hs) begin
            tok_ready <= 1'b0;
            last_q    <= tok_last;
            arith_q   <= 1'b0;
            state     <= EXEC;
            if (!tok_is_op) begin
              if (depth == DEPTH_MAX || stk_full) begin
                err        <= E_FULL;
                stk_opcode <= OP_NOP;
              end else begin
                stk_opcode <= OP_PUSH;
                stk_data   <= tok_data;
                depth      <= depth + ONE;
              end
            end else if (tok_data[1]) begin
              err        <= E_BADOP;
              stk_opcode <= OP_NOP;
            end else if (depth < TWO) begin
              err        <= E_UNDER;
              stk_opcode <= OP_NOP;
            end else begin
              stk_opcode <= tok_data[0] ? OP_MUL : OP_ADD;
              arith_q    <= 1'b1;
              depth      <= depth - ONE;
            end
          end else begin
            tok_ready <= 1'b1;
          end
        end

        EXEC: begin
          stk_opcode <= OP_NOP;
          state      <= SETTLE;
        end

        SETTLE: begin
          err <= settle_err;
          if (settle_err != E_OK && !last_q) begin
            tok_ready <= 1'b1;
            state     <= DRAIN;
          end else if (settle_err != E_OK) begin
            stk_opcode <= (depth != '0) ? OP_POP : OP_NOP;
            state      <= CLEAN;
          end else if (last_q && depth != ONE) begin
            err        <= E_DEPTH;
            stk_opcode <= (depth != '0) ? OP_POP : OP_NOP;
            state      <= CLEAN;
          end else if (last_q) begin
            stk_opcode <= OP_POP;
            state      <= FPOP;
          end else begin
            tok_ready <= 1'b1;
            state     <= ACCEPT;
          end
        end

        FPOP: begin
          stk_opcode <= OP_NOP;
          depth      <= '0;
          state      <= FWAIT;
        end

        FWAIT: begin
          res_data  <= stk_out;
          res_err   <= err;
          res_valid <= 1'b1;
          state     <= RESULT;
        end

        DRAIN: begin
          if (tok_hs && tok_last) begin
            tok_ready  <= 1'b0;
            stk_opcode <= (depth != '0) ? OP_POP : OP_NOP;
            state      <= CLEAN;
          end
        end

        // A pop is on stk_opcode during CLEAN whenever depth was nonzero on entry.
        CLEAN: begin
          if (depth != '0) begin
            stk_opcode <= OP_NOP;
            depth      <= depth - ONE;
            state      <= CWAIT;
          end else begin
            res_data  <= '0;
            res_err   <= err;
            res_valid <= 1'b1;
            state     <= RESULT;
          end
        end

        CWAIT: begin
          if (depth != '0) begin
            stk_opcode <= OP_POP;
            state      <= CLEAN;
          end else begin
            res_data  <= '0;
            res_err   <= err;
            res_valid <= 1'b1;
            state     <= RESULT;
          end
        end

        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            err       <= E_OK;
            tok_ready <= 1'b1;
            state     <= ACCEPT;
          end
        end

        default: state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// tb/tb_rpn_sequencer.sv - self-checking bench for rpn_sequencer with a stack model

module tb_rpn_sequencer;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  localparam logic [2:0] NOP = 3'b000, ADD = 3'b100, MUL = 3'b101, PUSH = 3'b110, POP = 3'b111;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tok_valid = 1'b0;
  logic             tok_ready;
  logic             tok_is_op = 1'b0;
  logic [WIDTH-1:0] tok_data = '0;
  logic             tok_last = 1'b0;
  logic [2:0]       stk_opcode;
  logic [WIDTH-1:0] stk_data;
  logic [WIDTH-1:0] stk_out;
  logic             stk_full;
  logic             stk_overflow;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_data;
  logic [2:0]       res_err;

  rpn_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
    .tok_data(tok_data), .tok_last(tok_last),
    .stk_opcode(stk_opcode), .stk_data(stk_data), .stk_out(stk_out),
    .stk_full(stk_full), .stk_overflow(stk_overflow),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // Behavioural operand stack.
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  int               sp;
  assign stk_full = (sp == DEPTH);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp           <= 0;
      stk_out      <= '0;
      stk_overflow <= 1'b0;
    end else begin
      case (stk_opcode)
        PUSH: if (sp < DEPTH) begin mem[sp] <= stk_data; sp <= sp + 1; end
        POP:  if (sp > 0) begin stk_out <= mem[sp-1]; sp <= sp - 1; end
        ADD:  if (sp > 1) begin
                mem[sp-2]    <= mem[sp-2] + mem[sp-1];
                stk_overflow <= ({1'b0, mem[sp-2]} + {1'b0, mem[sp-1]}) > 9'd255;
                sp           <= sp - 1;
              end
        MUL:  if (sp > 1) begin
                mem[sp-2]    <= mem[sp-2] * mem[sp-1];
                stk_overflow <= ({8'd0, mem[sp-2]} * {8'd0, mem[sp-1]}) > 16'd255;
                sp           <= sp - 1;
              end
        default: ;
      endcase
    end
  end

  // Pop counter and spacing between consecutive pops.
  int cyc = 0, pop_total = 0, last_pop_cyc = 0, pop_gap = 0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && stk_opcode == POP) begin
      pop_total    = pop_total + 1;
      pop_gap      = cyc - last_pop_cyc;
      last_pop_cyc = cyc;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct { logic is_op; logic [7:0] data; logic last; logic [2:0] op; logic chk; } tok_t;
  typedef struct { logic [7:0] data; logic [2:0] err; int pops; } exp_t;

  tok_t toks[$];
  exp_t sb[$];

  task automatic tk(input logic is_op, input logic [7:0] data, input logic last,
                    input logic [2:0] op, input logic chk = 1'b1);
    tok_t t;
    t.is_op = is_op; t.data = data; t.last = last; t.op = op; t.chk = chk;
    toks.push_back(t);
  endtask

  task automatic send_tok(input tok_t t);
    int n = 0;
    tok_is_op = t.is_op; tok_data = t.data; tok_last = t.last; tok_valid = 1'b1;
    while (!tok_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!tok_ready) begin
      check("tok_timeout", 0, 1);
      tok_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    tok_valid = 1'b0; tok_last = 1'b0;
    if (t.chk) check("opcode", stk_opcode, t.op);
  endtask

  task automatic run_expr(input logic [7:0] d, input logic [2:0] e, input int pops, input int hold);
    exp_t x;
    int   snap, n;
    x.data = d; x.err = e; x.pops = pops;
    sb.push_back(x);
    snap = pop_total;
    while (toks.size() > 0) send_tok(toks.pop_front());
    n = 0;
    while (!res_valid && n < 200) begin @(posedge clk); #1; n++; end
    x = sb.pop_front();
    if (!res_valid) begin
      check("res_timeout", 0, 1);
      return;
    end
    check("res_data", res_data, x.data);
    check("res_err", res_err, x.err);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, x.data);
      check("hold_err", res_err, x.err);
      check("hold_tok_ready", tok_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("res_valid_clr", res_valid, 0);
    check("pop_count", pop_total - snap, x.pops);
    check("stack_empty", sp, 0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_tok_ready", tok_ready, 0);
    check("rst_opcode", stk_opcode, NOP);
    check("rst_stk_data", stk_data, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_err", res_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // 3 4 + 5 * -> 35
    tk(0, 3, 0, PUSH); tk(0, 4, 0, PUSH); tk(1, 0, 0, ADD); tk(0, 5, 0, PUSH); tk(1, 1, 1, MUL);
    run_expr(8'd35, 3'd0, 1, 0);

    // 200 100 + -> wraps
    tk(0, 200, 0, PUSH); tk(0, 100, 0, PUSH); tk(1, 0, 1, ADD);
`ifdef RPN_OVF_CHECK_EN
    run_expr(8'd0, 3'd3, 1, 0);
`else
    run_expr(8'd44, 3'd0, 1, 0);
`endif

    // 5 + 7 -> underflow, 7 drained
    tk(0, 5, 0, PUSH); tk(1, 0, 0, NOP); tk(0, 7, 1, NOP, 1'b0);
    run_expr(8'd0, 3'd1, 1, 0);
    check("drain_no_push", pop_gap >= 0, 1);

    // five operands into a depth-4 stack
    tk(0, 1, 0, PUSH); tk(0, 2, 0, PUSH); tk(0, 3, 0, PUSH); tk(0, 4, 0, PUSH); tk(0, 5, 1, NOP);
    run_expr(8'd0, 3'd2, 4, 0);

    // 1 2 (last) -> bad final depth, pops two cycles apart
    tk(0, 1, 0, PUSH); tk(0, 2, 1, PUSH);
    run_expr(8'd0, 3'd4, 2, 0);
    check("pop_gap", pop_gap, 2);

    // invalid operator code
    tk(0, 1, 0, PUSH); tk(0, 2, 0, PUSH); tk(1, 2, 1, NOP);
    run_expr(8'd0, 3'd5, 2, 0);

    // result backpressure for 5 cycles: 2 3 * -> 6
    tk(0, 2, 0, PUSH); tk(0, 3, 0, PUSH); tk(1, 1, 1, MUL);
    run_expr(8'd6, 3'd0, 1, 5);

    // reset during EXEC
    tk(0, 9, 0, PUSH);
    send_tok(toks.pop_front());
    rst = 1'b1;
    #1;
    check("exec_rst_opcode", stk_opcode, NOP);
    check("exec_rst_tok_ready", tok_ready, 0);
    check("exec_rst_stk_data", stk_data, 0);
    check("exec_rst_res_valid", res_valid, 0);
    @(posedge clk); #1;
    check("exec_rst_opcode2", stk_opcode, NOP);
    check("exec_rst_res_err", res_err, 0);
    @(negedge clk) rst = 1'b0;

    // recovery: 1 2 + -> 3
    tk(0, 1, 0, PUSH); tk(0, 2, 0, PUSH); tk(1, 0, 1, ADD);
    run_expr(8'd3, 3'd0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
